sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised pixel compositor for the VGA pipeline. It merges N sprite/widget layers plus a background colour into one registered RGB stream. Layer priority is fixed, and per-layer enables are runtime. It also tracks per-frame collisions between visible layers. It sits between the widget instances and the VGA pins, alongside `VGALLDriver`, and feeds game logic with a frame strobe and latched collision results.

## Interface
Parameters:
- `N_LAYERS`, 4: number of layer inputs; index 0 has highest priority.
- `COLOR_W`, 4: bits per colour channel.
- `OVL_W`, 20: width of the overlap pixel counter.

Ports:
- `CLK_100MHz`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `HBlank`, `VBlank`  in  1 each  blanking from the VGA driver, aligned to the layer inputs.
- `layer_yes`  in  N_LAYERS  bit i high = layer i covers the current pixel.
- `layer_rgb`  in  N_LAYERS*3*COLOR_W  layer i colour at bits [i*3*COLOR_W +: 3*COLOR_W], ordered {R,G,B} MSB first.
- `layer_en`  in  N_LAYERS  runtime layer mask; a disabled layer is neither drawn nor counted for collisions.
- `bg_rgb`  in  3*COLOR_W  background colour {R,G,B}.
- `RED`, `GREEN`, `BLUE`  out  COLOR_W each  registered pixel colour.
- `blank_out`  out  1  HBlank|VBlank delayed to align with RGB.
- `frame_pulse`  out  1  one-cycle strobe at the start of each vertical blank.
- `collision_frame`  out  N_LAYERS  bit i set = layer i overlapped another enabled layer during the last completed frame.
- `overlap_count`  out  OVL_W  number of overlapping pixels in the last completed frame; saturating.

## Operation
- **Stage 1 (S1), registered:**
  - `vis = layer_yes & layer_en`.
  - `blank1 = HBlank | VBlank` and `vb1 = VBlank`.
  - Layer colours and `bg_rgb` are captured.
- **Stage 2 (S2), registered:**
  - If `blank1`, RGB = 0.
  - Otherwise RGB = colour of the lowest index i with `vis[i]`.
  - If no bit of `vis` is set, RGB = `bg_rgb`.
  - `blank_out` <= `blank1`.
- **Collision accumulation:** runs on each S1 sample with `blank1`=0 and popcount(`vis`) >= 2.
  - `acc_flags` <= `acc_flags | vis`.
  - `acc_count` <= `acc_count + 1`, saturating at 2^OVL_W−1.
  - A pixel with only one visible layer does nothing.
- **Frame boundary:** a rising edge is `vb1`=1 while the previous `vb1`=0. On that edge:
  - `collision_frame` <= `acc_flags` and `overlap_count` <= `acc_count`.
  - The accumulators clear to 0 and `frame_pulse`=1 for exactly that cycle.
  - The edge sample is blanked, so no accumulate/clear conflict exists.
- **Enable changes:** `layer_en` changes take effect on the next S1 capture. There is no frame-synchronisation requirement.
- **Reset (`Reset`=0 at a clock edge):**
  - Zero on the next edge: RGB, `blank_out`, `frame_pulse`, `collision_frame`, `overlap_count`, both accumulators and all S1 registers. `blank_out` resets to 1.
  - Previous-`vb1` register resets to 1, so a reset released inside vertical blank produces no spurious `frame_pulse`.
  - Mid-frame reset discards partial accumulation. The first reported frame after reset is the partial frame ending at the next VBlank rise.
- Widths are generic in all parameters; N_LAYERS=1 is legal (collisions never occur).

## Timing
- **Latency:**
  - Inputs sampled at edge k produce RGB and `blank_out` after edge k+1, i.e. 2 cycles.
  - Upstream HS/VS must be delayed 2 cycles by the integrator.
- **Frame events:**
  - `frame_pulse` and the updated `collision_frame`/`overlap_count` become valid on the same edge as the first `blank_out`=1 sample of vertical blank.
  - `collision_frame` and `overlap_count` are then stable for a full frame.
- Throughput is one pixel per clock; no stalls and no handshake.
- Saturation: `acc_count` holds at all-ones and does not wrap.

## Test plan
- **Priority:** N_LAYERS=4, `layer_en`=4'b1111, `layer_yes`=4'b0110, layer1 rgb=12'hF00, layer2=12'h0F0, blanks 0 -> RGB=F,0,0 two cycles later; `layer_yes`=0 with `bg_rgb`=12'h00A -> RGB=0,0,A.
- **Blanking and enable mask:** HBlank=1 with any layers -> RGB=0, `blank_out`=1; `layer_en`=4'b1101 with `layer_yes`=4'b0010 -> background shown and no collision counted.
- **Collision frame:** 5 active pixels with `vis`=4'b0011, then 3 with 4'b1001, then VBlank rise -> one-cycle `frame_pulse`, `collision_frame`=4'b1011, `overlap_count`=8. The next frame with no overlaps reports 0/0.
- **Saturation:** OVL_W=3, 10 overlapping pixels in one frame -> `overlap_count`=7.
- **Reset:**
  - Reset asserted mid-frame after 4 overlaps -> all outputs 0 next cycle and `blank_out`=1.
  - Release during VBlank=1 -> no `frame_pulse` until the following VBlank rise.
  - That frame reports only post-reset overlaps.
- **Latency:** step `layer_yes` at edge k -> RGB change observed exactly after edge k+1, aligned with `blank_out` transitions driven from the same input edge.

Source files
------------

// File: rtl/sprite_compositor.sv
// Fixed-priority layer compositor with per-frame collision tracking.
// Two-stage pipeline: S1 captures layer state, S2 produces the registered pixel and frame reports.
module sprite_compositor #(
  parameter int unsigned N_LAYERS = 4,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned OVL_W    = 20
) (
  input  logic                            CLK_100MHz,
  input  logic                            Reset,
  input  logic                            HBlank,
  input  logic                            VBlank,
  input  logic [N_LAYERS-1:0]             layer_yes,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]             layer_en,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  output logic [COLOR_W-1:0]              RED,
  output logic [COLOR_W-1:0]              GREEN,
  output logic [COLOR_W-1:0]              BLUE,
  output logic                            blank_out,
  output logic                            frame_pulse,
  output logic [N_LAYERS-1:0]             collision_frame,
  output logic [OVL_W-1:0]                overlap_count
);

  localparam int unsigned PixW = 3 * COLOR_W;

  // S1 registers
  logic [N_LAYERS-1:0]      vis_q;
  logic                     blank1_q;
  logic                     vb_prev_q;
  logic                     rise_q;
  logic [N_LAYERS*PixW-1:0] rgb_q;
  logic [PixW-1:0]          bg_q;

  // Per-frame accumulators
  logic [N_LAYERS-1:0]      acc_flags_q;
  logic [OVL_W-1:0]         acc_cnt_q;

  logic [PixW-1:0]          pix_d;
  logic                     multi_vis;

  // Walk from lowest priority up so the lowest visible index wins.
  always_comb begin
    pix_d = bg_q;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (vis_q[i]) pix_d = rgb_q[i*PixW +: PixW];
    end
    if (blank1_q) pix_d = '0;
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_vis = |(vis_q & (vis_q - N_LAYERS'(1)));

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset) begin
      vis_q           <= '0;
      blank1_q        <= 1'b0;
      vb_prev_q       <= 1'b1;
      rise_q          <= 1'b0;
      rgb_q           <= '0;
      bg_q            <= '0;
      acc_flags_q     <= '0;
      acc_cnt_q       <= '0;
      RED             <= '0;
      GREEN           <= '0;
      BLUE            <= '0;
      blank_out       <= 1'b1;
      frame_pulse     <= 1'b0;
      collision_frame <= '0;
      overlap_count   <= '0;
    end else begin
      vis_q    <= layer_yes & layer_en;
      blank1_q <= HBlank | VBlank;
      // Previous-VBlank copy resets high so a release inside VBlank sees no rise.
      vb_prev_q <= VBlank;
      rise_q    <= VBlank & ~vb_prev_q;
      rgb_q     <= layer_rgb;
      bg_q      <= bg_rgb;

      {RED, GREEN, BLUE} <= pix_d;
      blank_out          <= blank1_q;
      frame_pulse        <= rise_q;

      // The rise sample is always blanked, so report/clear never races accumulation.
      if (rise_q) begin
        collision_frame <= acc_flags_q;
        overlap_count   <= acc_cnt_q;
        acc_flags_q     <= '0;
        acc_cnt_q       <= '0;
      end else if (!blank1_q && multi_vis) begin
        acc_flags_q <= acc_flags_q | vis_q;
        if (acc_cnt_q != {OVL_W{1'b1}}) acc_cnt_q <= acc_cnt_q + OVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: per-cycle model compare plus directed literal checks.
// A second instance with a 3-bit overlap counter exercises saturation on the same stimulus.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hblank, vblank;
  logic [3:0]  layer_yes, layer_en;
  logic [47:0] layer_rgb;
  logic [11:0] bg_rgb;

  logic [3:0]  red, green, blue, s_red, s_green, s_blue;
  logic        blank_out, frame_pulse, s_blank_out, s_frame_pulse;
  logic [3:0]  collision_frame, s_collision_frame;
  logic [19:0] overlap_count;
  logic [2:0]  s_overlap_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_compositor #(.N_LAYERS(4), .COLOR_W(4), .OVL_W(20)) u_dut (
    .CLK_100MHz(clk), .Reset(reset_n), .HBlank(hblank), .VBlank(vblank),
    .layer_yes(layer_yes), .layer_rgb(layer_rgb), .layer_en(layer_en), .bg_rgb(bg_rgb),
    .RED(red), .GREEN(green), .BLUE(blue), .blank_out(blank_out), .frame_pulse(frame_pulse),
    .collision_frame(collision_frame), .overlap_count(overlap_count)
  );

  sprite_compositor #(.N_LAYERS(4), .COLOR_W(4), .OVL_W(3)) u_sat (
    .CLK_100MHz(clk), .Reset(reset_n), .HBlank(hblank), .VBlank(vblank),
    .layer_yes(layer_yes), .layer_rgb(layer_rgb), .layer_en(layer_en), .bg_rgb(bg_rgb),
    .RED(s_red), .GREEN(s_green), .BLUE(s_blue), .blank_out(s_blank_out),
    .frame_pulse(s_frame_pulse), .collision_frame(s_collision_frame),
    .overlap_count(s_overlap_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  vis;
    logic        blank;
    logic        rise;
    logic [47:0] rgb;
    logic [11:0] bg;
  } samp_t;

  samp_t       smp;
  logic        m_vb_prev;
  int          acc_cnt;
  logic [3:0]  acc_flags;
  logic [11:0] e_rgb;
  logic        e_blank, e_pulse;
  logic [3:0]  e_cf;
  int          e_cnt;

  function automatic logic [11:0] composite(input samp_t s);
    int k = 0;
    if (s.blank) return 12'h000;
    while (k < 4 && !s.vis[k]) k++;
    if (k == 4) return s.bg;
    return s.rgb[k*12 +: 12];
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      e_rgb = 12'h000; e_blank = 1'b1; e_pulse = 1'b0; e_cf = 4'h0; e_cnt = 0;
      acc_cnt = 0; acc_flags = 4'h0; m_vb_prev = 1'b1;
      smp = '{vis: 4'h0, blank: 1'b0, rise: 1'b0, rgb: 48'h0, bg: 12'h000};
    end else begin
      e_rgb   = composite(smp);
      e_blank = smp.blank;
      e_pulse = smp.rise;
      if (smp.rise) begin
        e_cf = acc_flags; e_cnt = acc_cnt; acc_flags = 4'h0; acc_cnt = 0;
      end else if (!smp.blank && $countones(smp.vis) >= 2) begin
        acc_flags = acc_flags | smp.vis;
        acc_cnt++;
      end
      smp.vis   = layer_yes & layer_en;
      smp.blank = hblank | vblank;
      smp.rise  = vblank && !m_vb_prev;
      m_vb_prev = vblank;
      smp.rgb   = layer_rgb;
      smp.bg    = bg_rgb;
    end
    #1;
    chk("rgb", {20'h0, red, green, blue}, {20'h0, e_rgb});
    chk("blank_out", {31'h0, blank_out}, {31'h0, e_blank});
    chk("frame_pulse", {31'h0, frame_pulse}, {31'h0, e_pulse});
    chk("collision_frame", {28'h0, collision_frame}, {28'h0, e_cf});
    chk("overlap_count", {12'h0, overlap_count}, (e_cnt > 20'hFFFFF) ? 32'hFFFFF : e_cnt);
    chk("sat_rgb", {20'h0, s_red, s_green, s_blue}, {20'h0, e_rgb});
    chk("sat_pulse", {31'h0, s_frame_pulse}, {31'h0, e_pulse});
    chk("sat_collision", {28'h0, s_collision_frame}, {28'h0, e_cf});
    chk("sat_overlap", {29'h0, s_overlap_count}, (e_cnt > 7) ? 32'd7 : e_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [3:0] yes, input logic [3:0] en, input logic hb,
                      input logic vb);
    layer_yes = yes; layer_en = en; hblank = hb; vblank = vb;
    @(negedge clk);
  endtask

  task automatic frame_end();
    step(4'h0, 4'hF, 1'b0, 1'b1);
    step(4'h0, 4'hF, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n   = 1'b0;
    layer_rgb = {12'h456, 12'h0F0, 12'hF00, 12'h123};
    bg_rgb    = 12'h00A;
    layer_yes = 4'h0; layer_en = 4'hF; hblank = 1'b0; vblank = 1'b1;
    repeat (3) step(4'h6, 4'hF, 1'b0, 1'b1);
    chk("lit_reset_rgb", {20'h0, red, green, blue}, 32'h0);
    chk("lit_reset_blank", {31'h0, blank_out}, 32'h1);

    // Release inside VBlank: no pulse until the next rise.
    reset_n = 1'b1;
    repeat (3) step(4'h0, 4'hF, 1'b0, 1'b1);
    chk("lit_no_pulse_release", {31'h0, frame_pulse}, 32'h0);

    // Frame 1: priority, blanking, enable mask.
    step(4'h6, 4'hF, 1'b0, 1'b0);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    chk("lit_priority", {20'h0, red, green, blue}, 32'hF00);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    chk("lit_background", {20'h0, red, green, blue}, 32'h00A);
    step(4'hF, 4'hF, 1'b1, 1'b0);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    chk("lit_hblank_rgb", {20'h0, red, green, blue}, 32'h0);
    chk("lit_hblank_flag", {31'h0, blank_out}, 32'h1);
    step(4'h2, 4'hD, 1'b0, 1'b0);
    step(4'h3, 4'hD, 1'b0, 1'b0);
    chk("lit_masked_bg", {20'h0, red, green, blue}, 32'h00A);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    chk("lit_masked_single", {20'h0, red, green, blue}, 32'h123);
    frame_end();
    chk("lit_f1_pulse", {31'h0, frame_pulse}, 32'h1);
    chk("lit_f1_flags", {28'h0, collision_frame}, 32'h6);
    chk("lit_f1_count", {12'h0, overlap_count}, 32'd1);
    step(4'h0, 4'hF, 1'b0, 1'b1);
    chk("lit_f1_pulse_off", {31'h0, frame_pulse}, 32'h0);
    step(4'h0, 4'hF, 1'b0, 1'b0);

    // Frame 2: 5 x 0011 then 3 x 1001.
    repeat (5) step(4'h3, 4'hF, 1'b0, 1'b0);
    repeat (3) step(4'h9, 4'hF, 1'b0, 1'b0);
    frame_end();
    chk("lit_f2_pulse", {31'h0, frame_pulse}, 32'h1);
    chk("lit_f2_flags", {28'h0, collision_frame}, 32'hB);
    chk("lit_f2_count", {12'h0, overlap_count}, 32'd8);
    chk("lit_f2_sat", {29'h0, s_overlap_count}, 32'd7);
    step(4'h0, 4'hF, 1'b0, 1'b1);
    step(4'h0, 4'hF, 1'b0, 1'b0);

    // Frame 3: no overlaps; latency of a single step.
    step(4'h4, 4'hF, 1'b0, 1'b0);
    chk("lit_latency_before", {20'h0, red, green, blue}, 32'h00A);
    step(4'h4, 4'hF, 1'b0, 1'b0);
    chk("lit_latency_after", {20'h0, red, green, blue}, 32'h0F0);
    repeat (3) step(4'h1, 4'hF, 1'b0, 1'b0);
    frame_end();
    chk("lit_f3_flags", {28'h0, collision_frame}, 32'h0);
    chk("lit_f3_count", {12'h0, overlap_count}, 32'd0);
    step(4'h0, 4'hF, 1'b0, 1'b0);

    // Frame 4: 10 overlaps, saturating the narrow counter.
    repeat (10) step(4'hF, 4'hF, 1'b0, 1'b0);
    frame_end();
    chk("lit_f4_flags", {28'h0, collision_frame}, 32'hF);
    chk("lit_f4_count", {12'h0, overlap_count}, 32'd10);
    chk("lit_f4_sat", {29'h0, s_overlap_count}, 32'd7);
    step(4'h0, 4'hF, 1'b0, 1'b0);

    // Mid-frame reset after 4 overlaps, released inside VBlank.
    repeat (4) step(4'h3, 4'hF, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(4'h3, 4'hF, 1'b0, 1'b0);
    chk("lit_rst_rgb", {20'h0, red, green, blue}, 32'h0);
    chk("lit_rst_blank", {31'h0, blank_out}, 32'h1);
    chk("lit_rst_flags", {28'h0, collision_frame}, 32'h0);
    chk("lit_rst_count", {12'h0, overlap_count}, 32'd0);
    step(4'h0, 4'hF, 1'b0, 1'b1);
    reset_n = 1'b1;
    repeat (3) step(4'h0, 4'hF, 1'b0, 1'b1);
    repeat (2) step(4'hC, 4'hF, 1'b0, 1'b0);
    repeat (2) step(4'h0, 4'hF, 1'b0, 1'b0);
    frame_end();
    chk("lit_post_rst_pulse", {31'h0, frame_pulse}, 32'h1);
    chk("lit_post_rst_flags", {28'h0, collision_frame}, 32'hC);
    chk("lit_post_rst_count", {12'h0, overlap_count}, 32'd2);
    repeat (3) step(4'h0, 4'hF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
